// File: rtl/seven_seg_scanner.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Holds a packed BCD value, walks the digits on a prescaled tick and drives
// one active-low anode at a time with that digit's active-low segment pattern.
// New values are staged and only committed at a frame boundary so a frame is
// never drawn from two different values.
module seven_seg_scanner #(
  parameter int DIGITS   = 4,
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1,
  localparam int CW      = $clog2(DIV),
  localparam int IW      = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic                  pending,
  output logic                  done,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            segment,
  output logic [IW-1:0]         dbg_idx
);

  // Load handshake: load is sampled on every rising edge and always captures
  // value/dp_in into the staging registers (latest load wins) and raises
  // pending. At frame_end, a pending value moves to the display registers,
  // done pulses for exactly one cycle and pending drops, unless a load lands
  // on that same edge, in which case the new value is staged and pending
  // stays high. There is no backpressure: load never has to wait.

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  frame_end;
  logic [4*DIGITS-1:0]   stg_val;
  logic [DIGITS-1:0]     stg_dp;
  logic [4*DIGITS-1:0]   shd_val;
  logic [DIGITS-1:0]     shd_dp;

  logic [DIGITS-1:0]     hi_zero;
  logic                  zero_acc;
  logic [3:0]            nib;
  logic                  nib_dp;
  logic                  nib_blank;
  logic [7:0]            seg_next;
  logic [DIGITS-1:0]     an_next;

  assign tick      = (cnt == CW'(DIV - 1));
  assign frame_end = tick && (idx == IW'(DIGITS - 1));
  assign dbg_idx   = idx;

  // Prescaler and digit index: idx steps once per DIV cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Staging/display registers and the load/commit handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_val <= '0;
      stg_dp  <= '0;
      shd_val <= '0;
      shd_dp  <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= frame_end && pending;
      if (frame_end && pending) begin
        shd_val <= stg_val;
        shd_dp  <= stg_dp;
      end
      if (load) begin
        stg_val <= value;
        stg_dp  <= dp_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // hi_zero[i] is set when display nibbles i..DIGITS-1 are all zero.
  always_comb begin
    hi_zero  = '0;
    zero_acc = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_acc   = zero_acc && (shd_val[4*i +: 4] == 4'd0);
      hi_zero[i] = zero_acc;
    end
  end

  // Select the current digit's nibble, dp and blanking flag, plus the anode.
  always_comb begin
    nib       = 4'd0;
    nib_dp    = 1'b0;
    nib_blank = 1'b0;
    an_next   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib        = shd_val[4*i +: 4];
        nib_dp     = shd_dp[i];
        nib_blank  = (i != 0) && hi_zero[i];
        an_next[i] = 1'b0;
      end
    end
  end

  // Decode to active-low {dp,g,f,e,d,c,b,a}; non-BCD nibbles show blank.
  always_comb begin
    case (nib)
      4'd0:    seg_next = 8'hC0;
      4'd1:    seg_next = 8'hF9;
      4'd2:    seg_next = 8'hA4;
      4'd3:    seg_next = 8'hB0;
      4'd4:    seg_next = 8'h99;
      4'd5:    seg_next = 8'h92;
      4'd6:    seg_next = 8'h82;
      4'd7:    seg_next = 8'hF8;
      4'd8:    seg_next = 8'h80;
      4'd9:    seg_next = 8'h90;
      default: seg_next = 8'hFF;
    endcase
    if (BLANK_LZ && nib_blank) seg_next = 8'hFF;
    // The decimal point still lights on a blanked digit.
    if (nib_dp) seg_next[7] = 1'b0;
  end

  // Registered pin drivers, refreshed every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an      <= '1;
      segment <= 8'hFF;
    end else begin
      an      <= an_next;
      segment <= seg_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with DIGITS=4, DIV=4. Two instances share the
// inputs: one blanks leading zeros, one shows all digits.
module tb_seven_seg_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;
  localparam logic [7:0] LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  always #5 clk = ~clk;

  logic       pend_b, done_b, pend_n, done_n;
  logic [3:0] an_b, an_n;
  logic [7:0] seg_b, seg_n;
  logic [1:0] idx_b, idx_n;

  seven_seg_scanner #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_LZ(1'b1)) u_blank (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .pending(pend_b), .done(done_b), .an(an_b), .segment(seg_b), .dbg_idx(idx_b)
  );

  seven_seg_scanner #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_LZ(1'b0)) u_noblank (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .pending(pend_n), .done(done_n), .an(an_n), .segment(seg_n), .dbg_idx(idx_n)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time since reset release is counted in edges; digit position is plain
  // division of that count. Values move stage -> display as a whole.
  int          e;
  bit          m_pend;
  logic [15:0] m_stg, m_shd;
  logic [3:0]  m_stg_dp, m_shd_dp;
  logic [3:0]  exp_an;
  logic [7:0]  exp_seg_b, exp_seg_n;
  bit          exp_done;
  int          exp_idx;

  function automatic logic [7:0] ref_seg(input logic [15:0] v, input logic [3:0] dp,
                                         input int i, input bit blz);
    logic [15:0] upper;
    int          n;
    logic [7:0]  s;
    upper = v >> (4 * i);
    n     = int'(upper & 16'hF);
    s     = (n < 10) ? LUT[n] : 8'hFF;
    if (blz && i > 0 && upper == 16'h0) s = 8'hFF;
    if (dp[i]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    e = 0; m_pend = 0;
    m_stg = '0; m_shd = '0; m_stg_dp = '0; m_shd_dp = '0;
    exp_an = 4'hF; exp_seg_b = 8'hFF; exp_seg_n = 8'hFF;
    exp_done = 0; exp_idx = 0;
  endtask

  // Predict the outputs after the coming rising edge.
  task automatic model_edge(input bit l, input logic [15:0] v, input logic [3:0] d);
    int cur;
    bit fe;
    cur       = (e / DIV) % DIGITS;
    fe        = ((e % DIV) == DIV - 1) && (cur == DIGITS - 1);
    exp_an    = ~(4'b0001 << cur);
    exp_seg_b = ref_seg(m_shd, m_shd_dp, cur, 1'b1);
    exp_seg_n = ref_seg(m_shd, m_shd_dp, cur, 1'b0);
    exp_done  = fe && m_pend;
    if (exp_done) begin
      m_shd    = m_stg;
      m_shd_dp = m_stg_dp;
    end
    if (l) begin
      m_stg = v; m_stg_dp = d; m_pend = 1;
    end else if (fe) begin
      m_pend = 0;
    end
    e++;
    exp_idx = (e / DIV) % DIGITS;
  endtask

  // ---------------- driver ----------------
  // Drive inputs just after a falling edge, let one rising edge pass, and
  // compare at the next falling edge.
  task automatic cyc(input bit l, input logic [15:0] v, input logic [3:0] d);
    load = l; value = v; dp_in = d;
    model_edge(l, v, d);
    @(negedge clk);
    check("an_b",   an_b,   exp_an);
    check("an_n",   an_n,   exp_an);
    check("seg_b",  seg_b,  exp_seg_b);
    check("seg_n",  seg_n,  exp_seg_n);
    check("done_b", done_b, exp_done);
    check("done_n", done_n, exp_done);
    check("pend_b", pend_b, m_pend);
    check("pend_n", pend_n, m_pend);
    check("idx_b",  idx_b,  exp_idx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 4'h0);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!exp_done && n < 2 * FRAME) begin
      cyc(1'b0, 16'h0, 4'h0);
      n++;
    end
    checks++;
    if (!exp_done) begin
      errors++;
      $display("FAIL %s: no commit within %0d cycles", nm, 2 * FRAME);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [31:0] segs_b;   // {digit3, digit2, digit1, digit0}
    logic [31:0] segs_n;
  } vec_t;

  vec_t tbl [6];

  int          dcount;
  logic [7:0]  seg_cap;
  bit          seen;

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : main
    tbl[0] = '{16'h1234, 4'b0000, 32'hF9A4B099, 32'hF9A4B099};
    tbl[1] = '{16'h0705, 4'b0001, 32'hFFF8C012, 32'hC0F8C012};
    tbl[2] = '{16'h00AF, 4'b0000, 32'hFFFFFFFF, 32'hC0C0FFFF};
    tbl[3] = '{16'h0009, 4'b0000, 32'hFFFFFF90, 32'hC0C0C090};
    tbl[4] = '{16'h0000, 4'b1000, 32'h7FFFFFC0, 32'h40C0C0C0};
    tbl[5] = '{16'h9080, 4'b0110, 32'h904000C0, 32'h904000C0};

    // Reset state.
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_an",   an_b,   4'hF);
    check("rst_seg",  seg_b,  8'hFF);
    check("rst_done", done_b, 1'b0);
    check("rst_pend", pend_b, 1'b0);
    rst = 1'b0;

    // Free-running scan of the reset value: 0 on digit 0, rest blanked.
    idle(20);

    // Table: load each value, wait for commit, read one full frame.
    for (int t = 0; t < 6; t++) begin
      cyc(1'b1, tbl[t].value, tbl[t].dp);
      wait_done($sformatf("tbl%0d_commit", t));
      for (int dg = 0; dg < DIGITS; dg++) begin
        cyc(1'b0, 16'h0, 4'h0);
        check($sformatf("tbl%0d_d%0d_b", t, dg), seg_b, tbl[t].segs_b[8*dg +: 8]);
        check($sformatf("tbl%0d_d%0d_n", t, dg), seg_n, tbl[t].segs_n[8*dg +: 8]);
        idle(DIV - 1);
      end
    end

    // Two loads inside one frame: only one commit, latest value wins.
    while ((e % FRAME) != 0) idle(1);
    cyc(1'b1, 16'h0001, 4'h0);
    idle(2);
    cyc(1'b1, 16'h0009, 4'h0);
    dcount = 0; seen = 0; seg_cap = 8'h00;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'h0, 4'h0);
      if (seen) begin
        seg_cap = seg_b;
        seen = 0;
      end
      if (done_b) begin
        dcount++;
        seen = 1;
      end
    end
    check("dbl_done_count", dcount, 1);
    check("dbl_digit0", seg_cap, 8'h90);

    // Load landing exactly on the frame_end edge.
    cyc(1'b1, 16'h0042, 4'h0);
    while ((e % FRAME) != FRAME - 1) idle(1);
    cyc(1'b1, 16'h0777, 4'h0);
    check("fe_load_done", done_b, 1'b1);
    check("fe_load_pend", pend_b, 1'b1);
    wait_done("fe_load_commit");
    idle(2 * FRAME);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom_range(0, 15)));
    end
    idle(FRAME);

    // Reset in mid-frame with a value staged.
    cyc(1'b1, 16'h4321, 4'h0);
    idle(2);
    load = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_an_b",   an_b,   4'hF);
    check("mid_rst_seg_b",  seg_b,  8'hFF);
    check("mid_rst_pend_b", pend_b, 1'b0);
    check("mid_rst_an_n",   an_n,   4'hF);
    check("mid_rst_seg_n",  seg_n,  8'hFF);
    check("mid_rst_done_b", done_b, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      cyc(1'b0, 16'h0, 4'h0);
      if (done_b || done_n) dcount++;
    end
    check("post_rst_no_done", dcount, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
